qr_axis_col_rx: RTL and testbench

- AXI-Stream slave that receives one QR-CORDIC input matrix as NUM_COL column beats of TBITS bits each into an internal column buffer.
- Presents the captured matrix to the CORDIC core through a registered random-access read port, with a valid/ack handover.
- Sits inside yolo_top between the S_AXIS_MM2S port and the QR core; it is the receiving end of the MM2S stream.

---
 rtl/qr_axis_col_rx.sv | 135 +++++++++++++
 tb/tb_qr_axis_col_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_axis_col_rx.sv
// AXI-Stream column receiver for the QR-CORDIC core: captures one NUM_COL-column
// matrix frame and serves it to the core through a registered read port.
module qr_axis_col_rx #(
  parameter int TBITS   = 64,
  parameter int TBYTE   = 8,
  parameter int NUM_COL = 8,
  parameter int IDX_W   = 3
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               S_AXIS_MM2S_TVALID,
  output logic               S_AXIS_MM2S_TREADY,
  input  logic [TBITS-1:0]   S_AXIS_MM2S_TDATA,
  input  logic [TBYTE-1:0]   S_AXIS_MM2S_TKEEP,
  input  logic               S_AXIS_MM2S_TLAST,
  output logic               mat_valid,
  input  logic               mat_ack,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [TBITS-1:0]   rd_data,
  output logic [IDX_W:0]     col_cnt,
  output logic               err_short,
  output logic               err_nolast
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FULL
  } state_t;

  state_t state, state_next;

  logic [TBITS-1:0]   col_buf [NUM_COL];
  logic [NUM_COL-1:0] mask;
  logic [TBITS-1:0]   keep_data;
  logic [IDX_W-1:0]   wr_idx;
  logic               accept;
  logic               last_col;
  logic               frame_end;
  logic               release_buf;
  logic               rd_hit;

  assign accept      = S_AXIS_MM2S_TVALID & S_AXIS_MM2S_TREADY;
  assign wr_idx      = col_cnt[IDX_W-1:0];
  assign last_col    = (col_cnt == CNT_W'(NUM_COL - 1));
  assign frame_end   = accept & (last_col | S_AXIS_MM2S_TLAST);
  assign release_buf = (state == FULL) & mat_ack;
  assign mat_valid   = (state == FULL);
  assign rd_hit      = ({1'b0, rd_addr} < CNT_W'(NUM_COL)) && mask[rd_addr];

  // Bytes without TKEEP are stored as zero so the core never sees stale data.
  always_comb begin
    keep_data = '0;
    for (int i = 0; i < TBYTE; i++) begin
      if (S_AXIS_MM2S_TKEEP[i]) begin
        keep_data[8*i +: 8] = S_AXIS_MM2S_TDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RECV: begin
        if (accept) begin
          state_next = frame_end ? FULL : RECV;
        end
      end
      FULL: begin
        if (mat_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // TREADY is a registered function of the upcoming state, independent of TVALID.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      S_AXIS_MM2S_TREADY <= 1'b0;
    end else begin
      S_AXIS_MM2S_TREADY <= (state_next != FULL);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      col_cnt    <= '0;
      mask       <= '0;
      err_short  <= 1'b0;
      err_nolast <= 1'b0;
    end else if (release_buf) begin
      col_cnt    <= '0;
      mask       <= '0;
      err_short  <= 1'b0;
      err_nolast <= 1'b0;
    end else if (accept) begin
      col_cnt      <= col_cnt + CNT_W'(1);
      mask[wr_idx] <= 1'b1;
      if (S_AXIS_MM2S_TLAST && !last_col) begin
        err_short <= 1'b1;
      end
      if (last_col && !S_AXIS_MM2S_TLAST) begin
        err_nolast <= 1'b1;
      end
    end
  end

  // Column storage needs no reset: the mask gates every read.
  always_ff @(posedge aclk) begin
    if (accept) begin
      col_buf[wr_idx] <= keep_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_hit ? col_buf[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_qr_axis_col_rx.sv
// Directed self-checking bench for qr_axis_col_rx: framing, errors, TKEEP,
// handover with mat_ack, stalls and mid-frame reset.
module tb_qr_axis_col_rx;

  logic        clk;
  logic        areset;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        mat_valid;
  logic        mat_ack;
  logic [2:0]  rd_addr;
  logic [63:0] rd_data;
  logic [3:0]  col_cnt;
  logic        err_short;
  logic        err_nolast;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc_cnt  = 0;

  qr_axis_col_rx #(.TBITS(64), .TBYTE(8), .NUM_COL(8), .IDX_W(3)) dut (
    .aclk               (clk),
    .areset             (areset),
    .S_AXIS_MM2S_TVALID (tvalid),
    .S_AXIS_MM2S_TREADY (tready),
    .S_AXIS_MM2S_TDATA  (tdata),
    .S_AXIS_MM2S_TKEEP  (tkeep),
    .S_AXIS_MM2S_TLAST  (tlast),
    .mat_valid          (mat_valid),
    .mat_ack            (mat_ack),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .col_cnt            (col_cnt),
    .err_short          (err_short),
    .err_nolast         (err_nolast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!areset && tvalid && tready) acc_cnt++;
  end

  // All tasks start and end at a falling edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           output int stalls);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; stalls = 0;
    while (!tready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!tready) begin
      chk_cnt++;
      $display("[TB] FAIL send_timeout: tready=%0b required 1", tready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic read_col(input logic [2:0] a, output logic [63:0] d);
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic pulse_ack();
    mat_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mat_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; mat_ack = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    areset = 1'b1;
    #1;
    chk_cnt++; if (tready !== 1'b0) $display("[TB] FAIL reset_tready: got %0b want 0", tready); else pass_cnt++;
    chk_cnt++; if (mat_valid !== 1'b0) $display("[TB] FAIL reset_mat_valid: got %0b want 0", mat_valid); else pass_cnt++;
    chk_cnt++; if (col_cnt !== 4'd0) $display("[TB] FAIL reset_col_cnt: got %0d want 0", col_cnt); else pass_cnt++;
    chk_cnt++; if (rd_data !== 64'd0) $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); else pass_cnt++;
    chk_cnt++; if ({err_short, err_nolast} !== 2'b00) $display("[TB] FAIL reset_errs: got %b want 00", {err_short, err_nolast}); else pass_cnt++;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    chk_cnt++; if (tready !== 1'b1) $display("[TB] FAIL tready_after_release: got %0b want 1", tready); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int st, st_sum;
    logic [63:0] d;
    st_sum = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(64'h0101_0101_0101_0101 * 64'(i + 1), 8'hFF, i == 7, st);
      st_sum += st;
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk_cnt++; if (st_sum !== 0) $display("[TB] FAIL full_stalls: got %0d want 0", st_sum); else pass_cnt++;
    chk_cnt++; if (mat_valid !== 1'b1) $display("[TB] FAIL full_mat_valid: got %0b want 1", mat_valid); else pass_cnt++;
    chk_cnt++; if (tready !== 1'b0) $display("[TB] FAIL full_tready: got %0b want 0", tready); else pass_cnt++;
    chk_cnt++; if (col_cnt !== 4'd8) $display("[TB] FAIL full_col_cnt: got %0d want 8", col_cnt); else pass_cnt++;
    chk_cnt++; if ({err_short, err_nolast} !== 2'b00) $display("[TB] FAIL full_errs: got %b want 00", {err_short, err_nolast}); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      read_col(3'(i), d);
      chk_cnt++;
      if (d !== 64'h0101_0101_0101_0101 * 64'(i + 1)) $display("[TB] FAIL full_rd%0d: got %h want %h", i, d, 64'h0101_0101_0101_0101 * 64'(i + 1));
      else pass_cnt++;
    end
    pulse_ack();
    chk_cnt++; if (mat_valid !== 1'b0) $display("[TB] FAIL ack_mat_valid: got %0b want 0", mat_valid); else pass_cnt++;
    chk_cnt++; if (tready !== 1'b1) $display("[TB] FAIL ack_tready: got %0b want 1", tready); else pass_cnt++;
    chk_cnt++; if (col_cnt !== 4'd0) $display("[TB] FAIL ack_col_cnt: got %0d want 0", col_cnt); else pass_cnt++;
  endtask

  task automatic test_nolast();
    int st, acc0;
    logic [63:0] d;
    for (int i = 0; i < 8; i++) send_beat(64'h0101_0101_0101_0101 * 64'(i + 1), 8'hFF, 1'b0, st);
    chk_cnt++; if (err_nolast !== 1'b1) $display("[TB] FAIL nolast_err: got %0b want 1", err_nolast); else pass_cnt++;
    chk_cnt++; if (err_short !== 1'b0) $display("[TB] FAIL nolast_short: got %0b want 0", err_short); else pass_cnt++;
    chk_cnt++; if (mat_valid !== 1'b1) $display("[TB] FAIL nolast_mat_valid: got %0b want 1", mat_valid); else pass_cnt++;
    acc0 = acc_cnt;
    tvalid = 1'b1; tdata = 64'h9999_8888_7777_6666; tkeep = 8'hFF; tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (tready !== 1'b0) $display("[TB] FAIL stall9_tready: got %0b want 0", tready); else pass_cnt++;
    chk_cnt++; if (acc_cnt !== acc0) $display("[TB] FAIL stall9_accepts: got %0d want %0d", acc_cnt, acc0); else pass_cnt++;
    pulse_ack();
    chk_cnt++; if (acc_cnt !== acc0) $display("[TB] FAIL ackcycle_accepts: got %0d want %0d", acc_cnt, acc0); else pass_cnt++;
    chk_cnt++; if (err_nolast !== 1'b0) $display("[TB] FAIL ack_clears_err: got %0b want 0", err_nolast); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    chk_cnt++; if (col_cnt !== 4'd1) $display("[TB] FAIL beat9_col_cnt: got %0d want 1", col_cnt); else pass_cnt++;
    read_col(3'd0, d);
    chk_cnt++; if (d !== 64'h9999_8888_7777_6666) $display("[TB] FAIL beat9_rd0: got %h want 9999888877776666", d); else pass_cnt++;
    read_col(3'd1, d);
    chk_cnt++; if (d !== 64'd0) $display("[TB] FAIL beat9_rd1: got %h want 0", d); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_short();
    int st;
    logic [63:0] d;
    for (int i = 0; i < 3; i++) send_beat(64'h1111_0000_0000_0000 + 64'(i), 8'hFF, i == 2, st);
    tvalid = 1'b0; tlast = 1'b0;
    chk_cnt++; if (mat_valid !== 1'b1) $display("[TB] FAIL short_mat_valid: got %0b want 1", mat_valid); else pass_cnt++;
    chk_cnt++; if (err_short !== 1'b1) $display("[TB] FAIL short_err: got %0b want 1", err_short); else pass_cnt++;
    chk_cnt++; if (err_nolast !== 1'b0) $display("[TB] FAIL short_nolast: got %0b want 0", err_nolast); else pass_cnt++;
    chk_cnt++; if (col_cnt !== 4'd3) $display("[TB] FAIL short_col_cnt: got %0d want 3", col_cnt); else pass_cnt++;
    read_col(3'd2, d);
    chk_cnt++; if (d !== 64'h1111_0000_0000_0002) $display("[TB] FAIL short_rd2: got %h want 1111000000000002", d); else pass_cnt++;
    for (int i = 3; i < 8; i++) begin
      read_col(3'(i), d);
      chk_cnt++; if (d !== 64'd0) $display("[TB] FAIL short_rd%0d: got %h want 0", i, d); else pass_cnt++;
    end
    pulse_ack();
  endtask

  task automatic test_tkeep();
    int st;
    logic [63:0] d;
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, st);
    send_beat(64'h0123_4567_89AB_CDEF, 8'hA5, 1'b1, st);
    tvalid = 1'b0; tlast = 1'b0;
    read_col(3'd0, d);
    chk_cnt++; if (d !== 64'h0000_0000_FFFF_FFFF) $display("[TB] FAIL keep_0f: got %h want 00000000ffffffff", d); else pass_cnt++;
    read_col(3'd1, d);
    chk_cnt++; if (d !== 64'h0100_4500_00AB_00EF) $display("[TB] FAIL keep_a5: got %h want 0100450000ab00ef", d); else pass_cnt++;
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    int st, acc0;
    int gaps [8] = '{0, 2, 1, 0, 3, 0, 1, 2};
    logic [63:0] d;
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      tvalid = 1'b0;
      repeat (gaps[i]) @(negedge clk);
      send_beat({32'hA5A5_0000 + 32'(i), 32'h1234_0000 + 32'(i)}, 8'hFF, 1'b0, st);
    end
    tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_col(3'(i), d);
      chk_cnt++;
      if (d !== {32'hA5A5_0000 + 32'(i), 32'h1234_0000 + 32'(i)}) $display("[TB] FAIL b2b_a_rd%0d: got %h", i, d);
      else pass_cnt++;
    end
    tvalid = 1'b1; tdata = {32'hB0B0_0000, 32'h5678_0000}; tkeep = 8'hFF; tlast = 1'b0;
    pulse_ack();
    for (int i = 0; i < 8; i++) begin
      send_beat({32'hB0B0_0000 + 32'(i), 32'h5678_0000 + 32'(i)}, 8'hFF, 1'b0, st);
      tvalid = 1'b0;
      repeat (gaps[7 - i]) @(negedge clk);
    end
    chk_cnt++; if (acc_cnt - acc0 !== 16) $display("[TB] FAIL b2b_accepts: got %0d want 16", acc_cnt - acc0); else pass_cnt++;
    chk_cnt++; if (col_cnt !== 4'd8) $display("[TB] FAIL b2b_col_cnt: got %0d want 8", col_cnt); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      read_col(3'(i), d);
      chk_cnt++;
      if (d !== {32'hB0B0_0000 + 32'(i), 32'h5678_0000 + 32'(i)}) $display("[TB] FAIL b2b_b_rd%0d: got %h", i, d);
      else pass_cnt++;
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    int st;
    logic [63:0] d;
    for (int i = 0; i < 5; i++) send_beat(64'hDEAD_0000_0000_0000 + 64'(i), 8'hFF, 1'b0, st);
    tvalid = 1'b0;
    areset = 1'b1;
    #1;
    chk_cnt++; if (col_cnt !== 4'd0) $display("[TB] FAIL midrst_col_cnt: got %0d want 0", col_cnt); else pass_cnt++;
    chk_cnt++; if (mat_valid !== 1'b0) $display("[TB] FAIL midrst_mat_valid: got %0b want 0", mat_valid); else pass_cnt++;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    read_col(3'd0, d);
    chk_cnt++; if (d !== 64'd0) $display("[TB] FAIL midrst_rd0: got %h want 0", d); else pass_cnt++;
    for (int i = 0; i < 8; i++) send_beat(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, i == 7, st);
    tvalid = 1'b0; tlast = 1'b0;
    chk_cnt++; if (mat_valid !== 1'b1) $display("[TB] FAIL midrst_full: got %0b want 1", mat_valid); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      read_col(3'(i), d);
      chk_cnt++;
      if (d !== 64'hC0DE_0000_0000_0000 + 64'(i)) $display("[TB] FAIL midrst_rd%0d: got %h", i, d);
      else pass_cnt++;
    end
    pulse_ack();
  endtask

  initial begin
    areset = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    mat_ack = 1'b0; rd_addr = '0;
    test_reset();
    test_full_frame();
    test_nolast();
    test_short();
    test_tkeep();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
